// File: rtl/bus_responder.sv
// Core-side bus responder: zero-stall HRAM/IE, stalled external accesses with ack/timeout.
// External accesses run IDLE -> WAIT -> DONE; DONE gives the core one unstalled cycle to retire.
module bus_responder #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  ie_reg,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    hram [0:126];

  logic is_ie, is_hram, is_ext, acc;
  assign is_ie   = (cpu_addr == 16'hFFFF);
  assign is_hram = (cpu_addr[15:7] == 9'h1FF) && !is_ie;
  assign is_ext  = !(is_ie || is_hram);
  assign acc     = cpu_rd || cpu_wr;

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    case (state)
      IDLE: if (acc && is_ext) begin
        cpu_stall = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (ext_ack || cnt == TMAX) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // HRAM has no reset; contents are undefined after power-up or reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_wr && is_hram) hram[cpu_addr[6:0]] <= cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
      cpu_rdata <= 8'h00;
      ie_reg    <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (acc) begin
          if (is_ext) begin
            ext_addr  <= cpu_addr;
            ext_we    <= cpu_wr;
            ext_wdata <= cpu_wdata;
            ext_req   <= 1'b1;
            cnt       <= '0;
          end else if (cpu_wr) begin
            if (is_ie) ie_reg <= cpu_wdata;
          end else begin
            cpu_rdata <= is_ie ? ie_reg : hram[cpu_addr[6:0]];
          end
        end
        WAIT: begin
          // Ack wins over a coinciding timeout.
          if (ext_ack) begin
            ext_req <= 1'b0;
            if (!ext_we) cpu_rdata <= ext_rdata;
          end else if (cnt == TMAX) begin
            ext_req <= 1'b0;
            bus_err <= 1'b1;
            if (!ext_we) cpu_rdata <= 8'hFF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder against a transaction-level reference model.
module tb_bus_responder;
  localparam int TO = 15;

  logic        clk = 1'b0, rst_n;
  logic [15:0] cpu_addr, ext_addr;
  logic        cpu_rd, cpu_wr, cpu_stall, ext_req, ext_we, ext_ack, bus_err;
  logic [7:0]  cpu_wdata, cpu_rdata, ext_wdata, ext_rdata, ie_reg;

  bus_responder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ie_reg(ie_reg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] m_hram [0:126];
  logic [7:0] m_ie, m_rdata;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic req_exp);
    chk({tag, ".rdata"}, cpu_rdata, m_rdata);
    chk({tag, ".ie"}, ie_reg, m_ie);
    chk({tag, ".err"}, bus_err, m_err);
    chk({tag, ".req"}, ext_req, req_exp);
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
    ext_ack = 1'($urandom);
    @(negedge clk);
    chk("idle.stall", cpu_stall, 0);
    chk_state("idle", 0);
  endtask

  task automatic int_acc(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd; ext_ack = 1'($urandom);
    @(negedge clk);
    chk("int.stall", cpu_stall, 0);
    chk_state("int", 0);
    if (wr) begin
      if (a == 16'hFFFF) m_ie = wd; else m_hram[a - 16'hFF80] = wd;
    end else if (rd) begin
      m_rdata = (a == 16'hFFFF) ? m_ie : m_hram[a - 16'hFF80];
    end
  endtask

  // ack_at: index of the WAIT cycle carrying ext_ack; beyond TO means never acked.
  task automatic ext_acc(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd,
                         input int ack_at, input logic [7:0] rv);
    int k = 0;
    bit fin = 0;
    @(posedge clk); #1;
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd; ext_ack = 1'($urandom);
    @(negedge clk);
    chk("ext.idle.stall", cpu_stall, 1);
    chk_state("ext.idle", 0);
    while (!fin) begin
      @(posedge clk); #1;
      ext_ack = (k == ack_at);
      ext_rdata = (k == ack_at) ? rv : 8'($urandom);
      @(negedge clk);
      chk("ext.wait.stall", cpu_stall, 1);
      chk_state("ext.wait", 1);
      chk("ext.addr", ext_addr, a);
      chk("ext.we", ext_we, wr);
      chk("ext.wdata", ext_wdata, wd);
      if (k == ack_at) begin
        fin = 1;
        if (!wr) m_rdata = rv;
      end else if (k == TO) begin
        fin = 1;
        m_err = 1;
        if (!wr) m_rdata = 8'hFF;
      end
      k++;
    end
    @(posedge clk); #1;
    ext_ack = 1'($urandom); ext_rdata = 8'($urandom);
    @(negedge clk);
    chk("ext.done.stall", cpu_stall, 0);
    chk_state("ext.done", 0);
  endtask

  initial begin
    rst_n = 0; cpu_addr = 0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = 0; ext_ack = 0; ext_rdata = 0;
    m_ie = 0; m_rdata = 0; m_err = 0;
    #12;
    chk_state("reset", 0);
    chk("reset.addr", ext_addr, 16'h0000);
    chk("reset.we", ext_we, 0);
    chk("reset.wdata", ext_wdata, 8'h00);
    @(negedge clk); rst_n = 1;

    // Known HRAM contents so every later read has a defined expectation.
    for (int i = 0; i < 127; i++) int_acc(16'hFF80 + 16'(i), 0, 1, 8'($urandom));

    int_acc(16'hFF80, 0, 1, 8'h5A);
    int_acc(16'hFF80, 1, 0, 8'h00);
    idle_cyc();
    chk("d.hram_rd", cpu_rdata, 8'h5A);
    int_acc(16'hFFFF, 0, 1, 8'h1F);
    int_acc(16'hFFFF, 1, 0, 8'h00);
    idle_cyc();
    chk("d.ie_rd", cpu_rdata, 8'h1F);
    ext_acc(16'h0150, 1, 0, 8'h00, 3, 8'hC3);
    chk("d.ext_rd", cpu_rdata, 8'hC3);
    ext_acc(16'h8000, 1, 0, 8'h00, TO + 5, 8'h00);
    chk("d.timeout_err", bus_err, 1);
    chk("d.timeout_rd", cpu_rdata, 8'hFF);
    int_acc(16'hFF81, 0, 1, 8'h3C);
    int_acc(16'hFF81, 1, 0, 8'h00);
    idle_cyc();
    chk("d.post_to", cpu_rdata, 8'h3C);
    ext_acc(16'hC000, 1, 1, 8'h77, 2, 8'h99);
    ext_acc(16'h4000, 1, 0, 8'h00, TO, 8'hA5);
    ext_acc(16'h4001, 0, 1, 8'h12, 0, 8'h00);

    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 2) idle_cyc();
      else if (r < 7) begin
        logic [1:0] op = 2'($urandom_range(1, 3));
        int_acc(16'hFF80 + 16'($urandom_range(0, 127)), op[0], op[1], 8'($urandom));
      end else begin
        logic [1:0] op = 2'($urandom_range(1, 3));
        ext_acc(16'($urandom_range(0, 16'hFF7F)), op[0], op[1], 8'($urandom),
                $urandom_range(0, TO + 2), 8'($urandom));
      end
    end

    // Reset in the middle of an external access.
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_rd = 1; cpu_wr = 0; ext_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.pre_req", ext_req, 1);
    #2 rst_n = 0; cpu_rd = 0;
    #1;
    m_ie = 0; m_rdata = 0; m_err = 0;
    chk_state("rst.mid", 0);
    chk("rst.addr", ext_addr, 16'h0000);
    chk("rst.we", ext_we, 0);
    chk("rst.wdata", ext_wdata, 8'h00);
    chk("rst.stall", cpu_stall, 0);
    @(negedge clk); rst_n = 1;
    idle_cyc();
    int_acc(16'hFF90, 0, 1, 8'hE7);
    int_acc(16'hFF90, 1, 0, 8'h00);
    idle_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
